// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Arbitrates two byte requesters onto a UART register block. For each granted
// byte it programs CFG (only when the line settings changed or are unknown),
// writes TX_DATA, kicks CTRL, then polls STATUS.tx_done until it sees a fresh
// completion (a 0 followed by a 1), or gives up after TMO_MAX status reads.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   reqN_valid/reqN_data/reqN_ready  byte requesters 0 and 1 (ready is combinational)
//   cfg[4:0]                    {parity_type, parity_en, stop_bit_num, data_bit_num[1:0]}
//   waddr/wdata/wr_en/wack      register write master
//   raddr/rd_en/rack/rdata      register read master (rdata sampled the cycle after rd_en)
//   busy                        frame in progress
//   done/done_id                one-cycle completion pulse and owning requester
//   tmo_err                     one-cycle poll-timeout pulse (done_id valid with it)
module uart_tx_sched #(
    parameter int              TMO_W   = 16,
    parameter logic [TMO_W-1:0] TMO_MAX = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic [7:0]  req0_data,
    input  logic [7:0]  req1_data,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [4:0]  cfg,
    output logic [11:0] waddr,
    output logic [31:0] wdata,
    output logic        wr_en,
    input  logic        wack,
    output logic [11:0] raddr,
    output logic        rd_en,
    input  logic        rack,
    input  logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        done_id,
    output logic        tmo_err
);

    localparam logic [11:0] ADDR_TX_DATA = 12'h000;
    localparam logic [11:0] ADDR_CFG     = 12'h008;
    localparam logic [11:0] ADDR_CTRL    = 12'h00C;
    localparam logic [11:0] ADDR_STATUS  = 12'h010;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        WR_CFG = 4'd1,
        WT_CFG = 4'd2,
        WR_DAT = 4'd3,
        WT_DAT = 4'd4,
        WR_CTL = 4'd5,
        WT_CTL = 4'd6,
        RD_LO  = 4'd7,
        CK_LO  = 4'd8,
        RD_HI  = 4'd9,
        CK_HI  = 4'd10
    } state_t;

    state_t           state;
    logic             last_grant;
    logic [7:0]       tx_byte;
    logic             frame_id;
    logic [4:0]       frame_cfg;
    logic [4:0]       cfg_copy;
    logic             cfg_valid;
    logic [TMO_W-1:0] poll_cnt;

    // The read handshake is fire-and-forget; only tx_done matters in rdata.
    logic unused_inputs;
    assign unused_inputs = rack ^ (^rdata[31:1]);

    // Round-robin grant, offered only in IDLE and never while reset is held.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (rst_n && (state == IDLE)) begin
            // On contention the requester that did not win last time goes first.
            if (req0_valid && (!req1_valid || (last_grant == 1'b1))) begin
                req0_ready = 1'b1;
            end else begin
                req0_ready = 1'b0;
            end
            if (req1_valid && (!req0_valid || (last_grant == 1'b0))) begin
                req1_ready = 1'b1;
            end else begin
                req1_ready = 1'b0;
            end
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    // Frame sequencer: state, bus master outputs, cfg cache and poll counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            tx_byte    <= 8'h00;
            frame_id   <= 1'b0;
            frame_cfg  <= 5'h00;
            cfg_copy   <= 5'h00;
            cfg_valid  <= 1'b0;
            poll_cnt   <= {TMO_W{1'b0}};
            waddr      <= 12'h000;
            wdata      <= 32'h0000_0000;
            wr_en      <= 1'b0;
            raddr      <= 12'h000;
            rd_en      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_id    <= 1'b0;
            tmo_err    <= 1'b0;
        end else begin
            done    <= 1'b0;
            tmo_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        tx_byte    <= req1_ready ? req1_data : req0_data;
                        frame_id   <= req1_ready;
                        last_grant <= req1_ready;
                        frame_cfg  <= cfg;
                        busy       <= 1'b1;
                        wr_en      <= 1'b1;
                        if (!cfg_valid || (cfg != cfg_copy)) begin
                            state <= WR_CFG;
                            waddr <= ADDR_CFG;
                            wdata <= {27'd0, cfg};
                        end else begin
                            state <= WR_DAT;
                            waddr <= ADDR_TX_DATA;
                            wdata <= {24'd0, (req1_ready ? req1_data : req0_data)};
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WR_CFG: begin
                    wr_en <= 1'b0;
                    state <= WT_CFG;
                end
                WT_CFG: begin
                    if (wack) begin
                        cfg_copy  <= frame_cfg;
                        cfg_valid <= 1'b1;
                        wr_en     <= 1'b1;
                        waddr     <= ADDR_TX_DATA;
                        wdata     <= {24'd0, tx_byte};
                        state     <= WR_DAT;
                    end else begin
                        state <= WT_CFG;
                    end
                end
                WR_DAT: begin
                    wr_en <= 1'b0;
                    state <= WT_DAT;
                end
                WT_DAT: begin
                    if (wack) begin
                        wr_en <= 1'b1;
                        waddr <= ADDR_CTRL;
                        wdata <= 32'h0000_0001;
                        state <= WR_CTL;
                    end else begin
                        state <= WT_DAT;
                    end
                end
                WR_CTL: begin
                    wr_en <= 1'b0;
                    state <= WT_CTL;
                end
                WT_CTL: begin
                    if (wack) begin
                        rd_en    <= 1'b1;
                        raddr    <= ADDR_STATUS;
                        poll_cnt <= {TMO_W{1'b0}};
                        state    <= RD_LO;
                    end else begin
                        state <= WT_CTL;
                    end
                end
                RD_LO, RD_HI: begin
                    rd_en <= 1'b0;
                    if (poll_cnt != {TMO_W{1'b1}}) begin
                        poll_cnt <= poll_cnt + {{(TMO_W-1){1'b0}}, 1'b1};
                    end else begin
                        poll_cnt <= poll_cnt;
                    end
                    state <= (state == RD_LO) ? CK_LO : CK_HI;
                end
                CK_LO: begin
                    // Timeout is judged before the status bit, so the read
                    // budget is a hard cap on STATUS reads per frame.
                    if (poll_cnt >= TMO_MAX) begin
                        tmo_err   <= 1'b1;
                        done_id   <= frame_id;
                        cfg_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (rdata[0]) begin
                        // tx_done still set from an earlier frame: keep waiting for it to clear.
                        rd_en <= 1'b1;
                        state <= RD_LO;
                    end else begin
                        rd_en <= 1'b1;
                        state <= RD_HI;
                    end
                end
                CK_HI: begin
                    if (poll_cnt >= TMO_MAX) begin
                        tmo_err   <= 1'b1;
                        done_id   <= frame_id;
                        cfg_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (rdata[0]) begin
                        done    <= 1'b1;
                        done_id <= frame_id;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        rd_en <= 1'b1;
                        state <= RD_HI;
                    end
                end
                default: begin
                    wr_en <= 1'b0;
                    rd_en <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched
// Bench for uart_tx_sched (TMO_MAX=8). A register-block responder answers
// writes after a programmable delay and returns a scripted tx_done sequence
// for STATUS reads. A frame-level model predicts the write list, number of
// STATUS reads, the outcome (done or timeout) and the grant order.
module tb_uart_tx_sched;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic [4:0]  cfg;
    logic [11:0] waddr, raddr;
    logic [31:0] wdata, rdata;
    logic        wr_en, wack, rd_en, rack;
    logic        busy, done, done_id, tmo_err;

    always #5 clk = ~clk;

    uart_tx_sched #(.TMO_W(16), .TMO_MAX(16'd8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_data(req0_data), .req1_data(req1_data),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .cfg(cfg),
        .waddr(waddr), .wdata(wdata), .wr_en(wr_en), .wack(wack),
        .raddr(raddr), .rd_en(rd_en), .rack(rack), .rdata(rdata),
        .busy(busy), .done(done), .done_id(done_id), .tmo_err(tmo_err)
    );

    int checks = 0;
    int errors = 0;

    // Responder / monitor state
    logic [43:0] wq[$];
    logic [43:0] exp_w[$];
    int rd_cnt, hold_err, wr_long, both_cnt, rd_idx;
    int st_stale, st_zero, wack_dly;
    bit st_stuck;
    bit pend;
    int pcnt;
    logic prev_wr;
    logic [11:0] hold_a;
    logic [31:0] hold_d;

    // Frame-level reference model
    int   m_last;
    bit   m_cfg_valid;
    logic [4:0] m_cfg;
    int   exp_reads;
    bit   exp_done;

    // tx_done value returned for the i-th STATUS read of a frame
    function automatic logic status_bit(int i);
        if (st_stuck) return 1'b1;
        if (i < st_stale) return 1'b1;
        if (i < st_stale + st_zero) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int model_pick(bit v0, bit v1);
        if (v0 && v1) return (m_last == 1) ? 0 : 1;
        return v0 ? 0 : 1;
    endfunction

    // Predict one frame and advance the model past it
    function automatic void model_frame(logic [7:0] d, logic [4:0] c, int gid);
        int needed;
        exp_w.delete();
        if (!m_cfg_valid || c != m_cfg) exp_w.push_back({12'h008, 27'd0, c});
        exp_w.push_back({12'h000, 24'd0, d});
        exp_w.push_back({12'h00C, 32'd1});
        // stale ones, then zeros (first one moves to the high phase), then a one
        needed    = st_stuck ? 1000 : st_stale + st_zero + 1;
        exp_done  = (needed < TMO);
        exp_reads = exp_done ? needed : TMO;
        m_cfg       = c;
        m_cfg_valid = exp_done;
        m_last      = gid;
    endfunction

    function automatic bit writes_ok();
        if (wq.size() != exp_w.size()) return 1'b0;
        foreach (wq[i]) if (wq[i] !== exp_w[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Register-block responder and bus monitor, evaluated on the falling edge
    initial begin
        pend = 0; pcnt = 0; prev_wr = 1'b0; rd_idx = 0;
        forever begin
            @(negedge clk);
            wack = 1'b0;
            if (!rst_n) pend = 0;
            if ((req0_ready && req0_valid) || (req1_ready && req1_valid)) rd_idx = 0;
            if (wr_en && rd_en) both_cnt++;
            if (wr_en && prev_wr) wr_long++;
            prev_wr = wr_en;
            if (wr_en) begin
                wq.push_back({waddr, wdata});
                pend = 1; pcnt = 0; hold_a = waddr; hold_d = wdata;
            end else if (pend) begin
                if (waddr !== hold_a || wdata !== hold_d) hold_err++;
                if (pcnt >= wack_dly) begin wack = 1'b1; pend = 0; end
                else pcnt++;
            end
            if (rd_en) begin
                rdata = {31'd0, status_bit(rd_idx)};
                rd_idx++;
                rd_cnt++;
            end
        end
    end

    task automatic run_frame(input bit v0, input bit v1, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [4:0] c, output int gid, output int n_done, output int n_tmo,
                             output int fid, output int busy_bad, output int pulse_bad);
        gid = -1; n_done = 0; n_tmo = 0; fid = -1; busy_bad = 0; pulse_bad = 0;
        @(posedge clk); #1;
        wq.delete(); rd_cnt = 0; hold_err = 0; wr_long = 0; both_cnt = 0;
        req0_valid = v0; req1_valid = v1; req0_data = d0; req1_data = d1; cfg = c;
        for (int i = 0; i < 20 && gid < 0; i++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) gid = 0;
            else if (req1_valid && req1_ready) gid = 1;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        if (gid >= 0) begin
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (done || tmo_err) begin
                    if (done) n_done++;
                    if (tmo_err) n_tmo++;
                    fid = done_id;
                    if (busy) busy_bad++;
                    break;
                end
                if (!busy) busy_bad++;
            end
            @(negedge clk);
            if (done || tmo_err) pulse_bad++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
        end
        checks++;
        if ({busy, done, done_id, tmo_err, wr_en, rd_en} !== 6'd0 || waddr !== 12'h0 || raddr !== 12'h0 || wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b id=%b tmo=%b wr=%b rd=%b waddr=%h raddr=%h wdata=%h expected all 0",
                     busy, done, done_id, tmo_err, wr_en, rd_en, waddr, raddr, wdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        m_last = 1; m_cfg_valid = 0; m_cfg = 5'h00;
    endtask

    task automatic test_first_frame();
        int gid, nd, nt, fid, bb, pb;
        st_stale = 0; st_zero = 1; st_stuck = 0; wack_dly = 0;
        model_frame(8'hA5, 5'h03, 0);
        run_frame(1, 0, 8'hA5, 8'h00, 5'h03, gid, nd, nt, fid, bb, pb);
        checks++;
        if (!writes_ok()) begin
            errors++; $display("FAIL first_writes: got %0d writes [0]=%h [1]=%h [2]=%h expected %0d [0]=%h [1]=%h [2]=%h",
                               wq.size(), wq[0], wq[1], wq[2], exp_w.size(), exp_w[0], exp_w[1], exp_w[2]);
        end
        checks++;
        if (rd_cnt !== exp_reads) begin errors++; $display("FAIL first_reads: got %0d expected %0d", rd_cnt, exp_reads); end
        checks++;
        if (nd !== 1 || nt !== 0 || fid !== 0) begin
            errors++; $display("FAIL first_done: got done=%0d tmo=%0d id=%0d expected 1 0 0", nd, nt, fid);
        end
        checks++;
        if (bb !== 0 || pb !== 0 || both_cnt !== 0 || wr_long !== 0) begin
            errors++; $display("FAIL first_protocol: got busy_bad=%0d pulse_bad=%0d both=%0d wr_long=%0d expected 0", bb, pb, both_cnt, wr_long);
        end
    endtask

    task automatic test_cfg_reuse();
        int gid, nd, nt, fid, bb, pb;
        st_stale = 1; st_zero = 2;
        model_frame(8'h3C, 5'h03, 0);
        run_frame(1, 0, 8'h3C, 8'h00, 5'h03, gid, nd, nt, fid, bb, pb);
        checks++;
        if (wq.size() !== 2 || wq[0][43:32] !== 12'h000) begin
            errors++; $display("FAIL reuse_first_addr: got %0d writes first addr %h expected 2 writes first addr 000", wq.size(), wq[0][43:32]);
        end
        checks++;
        if (!writes_ok() || rd_cnt !== exp_reads || nd !== 1) begin
            errors++; $display("FAIL reuse_frame: got reads=%0d done=%0d expected reads=%0d done=1", rd_cnt, nd, exp_reads);
        end
    endtask

    task automatic test_back_to_back();
        int gq[$];
        int dq[$];
        int e0;
        st_stale = 0; st_zero = 1; wack_dly = 0;
        e0 = model_pick(1, 1);
        @(posedge clk); #1;
        req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'h11; req1_data = 8'h22; cfg = 5'h03;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) dq.push_back(int'(done_id));
            if (dq.size() == 3) break;
            if (req0_valid && req0_ready) gq.push_back(0);
            else if (req1_valid && req1_ready) gq.push_back(1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (gq.size() !== 3 || gq[0] !== e0 || gq[1] !== 1 - e0 || gq[2] !== e0) begin
            errors++; $display("FAIL b2b_grants: got n=%0d %0d,%0d,%0d expected %0d,%0d,%0d", gq.size(), gq[0], gq[1], gq[2], e0, 1 - e0, e0);
        end
        checks++;
        if (dq.size() !== 3 || dq[0] !== e0 || dq[1] !== 1 - e0 || dq[2] !== e0) begin
            errors++; $display("FAIL b2b_done_id: got n=%0d %0d,%0d,%0d expected %0d,%0d,%0d", dq.size(), dq[0], dq[1], dq[2], e0, 1 - e0, e0);
        end
        m_last = e0; m_cfg = 5'h03; m_cfg_valid = 1;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int gid, nd, nt, fid, bb, pb;
        st_stuck = 1; wack_dly = 1;
        model_frame(8'h77, 5'h03, 1);
        run_frame(0, 1, 8'h00, 8'h77, 5'h03, gid, nd, nt, fid, bb, pb);
        checks++;
        if (rd_cnt !== exp_reads) begin errors++; $display("FAIL tmo_reads: got %0d expected %0d", rd_cnt, exp_reads); end
        checks++;
        if (nt !== 1 || nd !== 0 || fid !== 1 || pb !== 0) begin
            errors++; $display("FAIL tmo_pulse: got tmo=%0d done=%0d id=%0d pulse_bad=%0d expected 1 0 1 0", nt, nd, fid, pb);
        end
        st_stuck = 0; st_stale = 0; st_zero = 1;
        model_frame(8'h78, 5'h03, 1);
        run_frame(0, 1, 8'h00, 8'h78, 5'h03, gid, nd, nt, fid, bb, pb);
        checks++;
        if (wq[0][43:32] !== 12'h008 || !writes_ok() || nd !== 1) begin
            errors++; $display("FAIL tmo_recfg: got first addr %h writes=%0d done=%0d expected 008 %0d 1", wq[0][43:32], wq.size(), nd, exp_w.size());
        end
    endtask

    task automatic test_wack_delay();
        int gid, nd, nt, fid, bb, pb;
        wack_dly = 3; st_stale = 1; st_zero = 1;
        model_frame(8'hC3, 5'h15, 0);
        run_frame(1, 0, 8'hC3, 8'h00, 5'h15, gid, nd, nt, fid, bb, pb);
        checks++;
        if (hold_err !== 0 || wr_long !== 0) begin
            errors++; $display("FAIL wack_hold: got hold_err=%0d wr_long=%0d expected 0 0", hold_err, wr_long);
        end
        checks++;
        if (!writes_ok() || rd_cnt !== exp_reads || nd !== 1 || fid !== 0) begin
            errors++; $display("FAIL wack_frame: got writes=%0d reads=%0d done=%0d id=%0d expected %0d %0d 1 0",
                               wq.size(), rd_cnt, nd, fid, exp_w.size(), exp_reads);
        end
    endtask

    task automatic test_reset_mid_frame();
        int gid, nd, nt, fid, bb, pb;
        int bad;
        bit seen;
        wack_dly = 6; st_stale = 0; st_zero = 1; seen = 0; bad = 0;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_data = 8'h5A; cfg = 5'h0B;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (wr_en && waddr === 12'h000) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rstmid_reach: got no TX_DATA write expected one"); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || wr_en !== 1'b0 || rd_en !== 1'b0 || req0_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_state: got busy=%b wr=%b rd=%b ready=%b expected 0 0 0 0", busy, wr_en, rd_en, req0_ready);
        end
        for (int i = 0; i < 4; i++) begin
            if (done || tmo_err || req0_ready) bad++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; req0_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || tmo_err) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rstmid_pulses: got %0d bad cycles expected 0", bad); end
        m_last = 1; m_cfg_valid = 0;
        wack_dly = 0;
        model_frame(8'h5A, 5'h0B, 0);
        run_frame(1, 0, 8'h5A, 8'h00, 5'h0B, gid, nd, nt, fid, bb, pb);
        checks++;
        if (wq[0][43:32] !== 12'h008 || !writes_ok() || nd !== 1) begin
            errors++; $display("FAIL rstmid_next: got first addr %h writes=%0d done=%0d expected 008 %0d 1", wq[0][43:32], wq.size(), nd, exp_w.size());
        end
    endtask

    task automatic test_random();
        int gid, nd, nt, fid, bb, pb, gexp, sel;
        bit v0, v1;
        logic [7:0] d0, d1;
        logic [4:0] c;
        for (int n = 0; n < 12; n++) begin
            sel = $urandom_range(0, 2);
            v0 = (sel != 1); v1 = (sel != 0);
            d0 = 8'($urandom); d1 = 8'($urandom);
            c = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'h03;
            st_stale = $urandom_range(0, 4); st_zero = $urandom_range(1, 4);
            wack_dly = $urandom_range(0, 3);
            gexp = model_pick(v0, v1);
            model_frame((gexp == 1) ? d1 : d0, c, gexp);
            run_frame(v0, v1, d0, d1, c, gid, nd, nt, fid, bb, pb);
            checks++;
            if (gid !== gexp || !writes_ok()) begin
                errors++; $display("FAIL rnd_grant_writes[%0d]: got gid=%0d writes=%0d first=%h expected gid=%0d writes=%0d first=%h",
                                   n, gid, wq.size(), wq[0], gexp, exp_w.size(), exp_w[0]);
            end
            checks++;
            if (rd_cnt !== exp_reads || nd !== int'(exp_done) || nt !== int'(!exp_done) || fid !== gexp) begin
                errors++; $display("FAIL rnd_outcome[%0d]: got reads=%0d done=%0d tmo=%0d id=%0d expected %0d %0d %0d %0d",
                                   n, rd_cnt, nd, nt, fid, exp_reads, exp_done, !exp_done, gexp);
            end
            checks++;
            if (bb !== 0 || pb !== 0 || both_cnt !== 0 || hold_err !== 0 || wr_long !== 0) begin
                errors++; $display("FAIL rnd_protocol[%0d]: got busy_bad=%0d pulse_bad=%0d both=%0d hold=%0d wr_long=%0d expected 0",
                                   n, bb, pb, both_cnt, hold_err, wr_long);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 8'h00; req1_data = 8'h00; cfg = 5'h00;
        wack = 1'b0; rack = 1'b0; rdata = 32'h0;
        st_stale = 0; st_zero = 1; st_stuck = 0; wack_dly = 0;
        rd_cnt = 0; hold_err = 0; wr_long = 0; both_cnt = 0;
        m_last = 1; m_cfg_valid = 0; m_cfg = 5'h00;
        test_reset();
        test_first_frame();
        test_cfg_reuse();
        test_back_to_back();
        test_timeout();
        test_wack_delay();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
